div_issue_ctrl: RTL

//   Sequences one divide/modulo operation of the EX stage onto the external divider IP (AXI-stream

---
 rtl/div_issue_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/div_issue_ctrl.sv
// Issue controller for one EX-stage divide/modulo op on an AXI-stream divider IP.
// Feeds the dividend/divisor channels independently, selects quotient or remainder, and drains the IP on flush.
module div_issue_ctrl #(
   parameter int DW    = 32,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req_valid,
   input  logic              req_signed,
   input  logic              req_mod,
   input  logic [DW-1:0]     req_src1,
   input  logic [DW-1:0]     req_src2,
   input  logic              flush,
   input  logic              res_ready,
   output logic              res_valid,
   output logic [DW-1:0]     res_data,
   output logic              busy,
   output logic              div_signed,
   output logic              dvd_tvalid,
   input  logic              dvd_tready,
   output logic [DW-1:0]     dvd_tdata,
   output logic              dvs_tvalid,
   input  logic              dvs_tready,
   output logic [DW-1:0]     dvs_tdata,
   input  logic              dout_tvalid,
   input  logic [2*DW-1:0]   dout_tdata,
   output logic [CNT_W-1:0]  lat_cycles
);

   typedef enum logic [2:0] {IDLE, SEND, WAIT, DONE, DRAIN} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DW-1:0]     src1_q;
   logic [DW-1:0]     src2_q;
   logic [DW-1:0]     res_q;
   logic              signed_q;
   logic              mod_q;
   logic              dvd_sent;
   logic              dvs_sent;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  lat_q;
   logic              accept;
   logic              capture;
   logic              drop_send;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A flush before either channel has handed over an operand withdraws tvalid in that
   // same cycle, so the IP never sees a beat and the op can be abandoned outright.
   always_comb begin
      state_nxt  = state;
      dvd_tvalid = 1'b0;
      dvs_tvalid = 1'b0;
      res_valid  = 1'b0;
      accept     = 1'b0;
      capture    = 1'b0;
      drop_send  = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && !flush) begin
               accept    = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            drop_send  = flush && !dvd_sent && !dvs_sent;
            dvd_tvalid = !dvd_sent && !drop_send;
            dvs_tvalid = !dvs_sent && !drop_send;
            if (flush) begin
               state_nxt = drop_send ? IDLE : DRAIN;
            end else if ((dvd_sent || dvd_tready) && (dvs_sent || dvs_tready)) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            // Result arriving in the flush cycle is consumed here, so nothing is left to drain.
            if (flush) begin
               state_nxt = dout_tvalid ? IDLE : DRAIN;
            end else if (dout_tvalid) begin
               capture   = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            res_valid = 1'b1;
            if (flush || res_ready) begin
               state_nxt = IDLE;
            end
         end
         DRAIN: begin
            dvd_tvalid = !dvd_sent;
            dvs_tvalid = !dvs_sent;
            if (dvd_sent && dvs_sent && dout_tvalid) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         src1_q   <= '0;
         src2_q   <= '0;
         signed_q <= 1'b0;
         mod_q    <= 1'b0;
         dvd_sent <= 1'b0;
         dvs_sent <= 1'b0;
         cnt_q    <= '0;
         res_q    <= '0;
         lat_q    <= '0;
      end else begin
         if (accept) begin
            src1_q   <= req_src1;
            src2_q   <= req_src2;
            signed_q <= req_signed;
            mod_q    <= req_mod;
            dvd_sent <= 1'b0;
            dvs_sent <= 1'b0;
            cnt_q    <= CNT_W'(1);
         end else begin
            if (dvd_tvalid && dvd_tready) begin
               dvd_sent <= 1'b1;
            end
            if (dvs_tvalid && dvs_tready) begin
               dvs_sent <= 1'b1;
            end
            if ((state == SEND || state == WAIT) && cnt_q != {CNT_W{1'b1}}) begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
         if (capture) begin
            res_q <= mod_q ? dout_tdata[DW-1:0] : dout_tdata[2*DW-1:DW];
            lat_q <= cnt_q;
         end
      end
   end

   assign busy       = (state != IDLE);
   assign res_data   = res_q;
   assign div_signed = signed_q;
   assign dvd_tdata  = src1_q;
   assign dvs_tdata  = src2_q;
   assign lat_cycles = lat_q;

endmodule
